// File: rtl/geffe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : geffe_pkg
// Brief   : Shared types and widths for the Geffe keystream controller.
// Rev     : 1.0
// ============================================================================
package geffe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned DIV_W     = 4;
  localparam int unsigned WARM_W    = 8;
  localparam int unsigned BYTE_W    = 8;

  function automatic logic is_active(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/geffe_clk_en.sv
`default_nettype none
// ============================================================================
// Module  : geffe_clk_en
// Brief   : Slow-LFSR enable divider; pulses slow_en_o on every (div_sel+1)th advance.
// Rev     : 1.0
// ============================================================================
module geffe_clk_en
  import geffe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [DIV_W-1:0] div_sel_i,
  output logic             slow_en_o
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             w_wrap;

  assign w_wrap    = (div_cnt_q == div_sel_i);
  assign slow_en_o = adv_i && w_wrap;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (adv_i) begin
      div_cnt_d = w_wrap ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/geffe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : geffe_ctrl
// Brief   : Session FSM, warm-up counter and byte packer for a Geffe generator.
// Rev     : 1.0
// ============================================================================
module geffe_ctrl
  import geffe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div_sel,
  input  logic [WARM_W-1:0] warmup,
  input  logic              ks_bit,
  output logic              lfsr_clr,
  output logic              fast_en,
  output logic              slow_en,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy
);

  state_e              state_q,      state_d;
  logic [DIV_W-1:0]    div_sel_q,    div_sel_d;
  logic [WARM_W-1:0]   warmup_q,     warmup_d;
  logic [WARM_W-1:0]   warm_cnt_q,   warm_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [BYTE_W-2:0]   shift_q,      shift_d;
  logic [BYTE_W-1:0]   byte_data_q,  byte_data_d;
  logic                byte_valid_q, byte_valid_d;

  logic w_stall;
  logic w_sample;
  logic w_load;
  logic w_xfer;
  logic w_abort;

  // Holding the 8th bit while the previous byte is still unaccepted keeps the
  // generator and the packer in lock-step, so no bit is lost or repeated.
  assign w_stall  = byte_valid_q && !byte_ready && (bit_cnt_q == '1);
  assign w_sample = fast_en && (state_q == ST_RUN);
  assign w_load   = w_sample && (bit_cnt_q == '1);
  assign w_xfer   = byte_valid_q && byte_ready;
  assign w_abort  = stop && is_active(state_q);

  // ---------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (stop)                state_d = ST_IDLE;
        else if (warmup_q != '0) state_d = ST_WARMUP;
        else                     state_d = ST_RUN;
      end
      ST_WARMUP: begin
        if (stop)                                  state_d = ST_IDLE;
        else if (fast_en && (warm_cnt_q == 8'd1))  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM outputs (an aborting cycle advances nothing)
  always_comb begin
    lfsr_clr = 1'b0;
    fast_en  = 1'b0;
    busy     = is_active(state_q);
    case (state_q)
      ST_CLEAR:  lfsr_clr = 1'b1;
      ST_WARMUP: fast_en  = !stop;
      ST_RUN:    fast_en  = !stop && !w_stall;
      default: begin
        lfsr_clr = 1'b0;
        fast_en  = 1'b0;
      end
    endcase
  end

  geffe_clk_en u_clk_en (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (lfsr_clr),
    .adv_i     (fast_en),
    .div_sel_i (div_sel_q),
    .slow_en_o (slow_en)
  );

  // ---------------- datapath next-state
  always_comb begin
    div_sel_d    = div_sel_q;
    warmup_d     = warmup_q;
    warm_cnt_d   = warm_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;

    if ((state_q == ST_IDLE) && start) begin
      div_sel_d = div_sel;
      warmup_d  = warmup;
    end

    if (state_q == ST_CLEAR) begin
      warm_cnt_d = warmup_q;
      bit_cnt_d  = '0;
      shift_d    = '0;
    end else if ((state_q == ST_WARMUP) && fast_en) begin
      warm_cnt_d = warm_cnt_q - 8'd1;
    end

    if (w_sample) begin
      if (w_load) begin
        byte_data_d = {shift_q, ks_bit};
        bit_cnt_d   = '0;
      end else begin
        shift_d   = {shift_q[BYTE_W-3:0], ks_bit};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end

    if (w_abort) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end

    // A load in the same cycle as a transfer keeps valid high with no bubble.
    if (w_load) begin
      byte_valid_d = 1'b1;
    end else if (w_xfer) begin
      byte_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_sel_q    <= '0;
      warmup_q     <= '0;
      warm_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      div_sel_q    <= div_sel_d;
      warmup_q     <= warmup_d;
      warm_cnt_q   <= warm_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_geffe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_geffe_ctrl
// Brief   : Directed self-checking bench for geffe_ctrl (keystream B2,5C,B2,...).
// Rev     : 1.0
// ============================================================================
module tb_geffe_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] div_sel;
  logic [7:0] warmup;
  logic       ks_bit;
  logic       lfsr_clr;
  logic       fast_en;
  logic       slow_en;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;

  logic [15:0] pat;
  logic [3:0]  idx;
  logic        feed;
  logic        idx_clr;

  int n_chk;
  int n_fail;

  geffe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .div_sel    (div_sel),
    .warmup     (warmup),
    .ks_bit     (ks_bit),
    .lfsr_clr   (lfsr_clr),
    .fast_en    (fast_en),
    .slow_en    (slow_en),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keystream source: advances only on consumed RUN bits, MSB of each byte first.
  assign ks_bit = pat[4'd15 - idx];

  always @(posedge clk) begin
    if (idx_clr)              idx <= 4'd0;
    else if (feed && fast_en) idx <= idx + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    pat = 16'hB25C; idx = 4'd0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_sel = 4'd0; warmup = 8'd0;
    byte_ready = 1'b1; feed = 1'b0; idx_clr = 1'b0;

    cyc(); cyc(); #1;
    chk("rst_clr",   32'(lfsr_clr),   0);
    chk("rst_fast",  32'(fast_en),    0);
    chk("rst_slow",  32'(slow_en),    0);
    chk("rst_data",  32'(byte_data),  0);
    chk("rst_valid", 32'(byte_valid), 0);
    chk("rst_busy",  32'(busy),       0);
    rst = 1'b0;

    // Session 1: warmup=3, div_sel=0
    cyc(); start = 1'b1; warmup = 8'd3; div_sel = 4'd0; idx_clr = 1'b1;
    cyc(); start = 1'b0; idx_clr = 1'b0; #1;
    chk("clr_strobe", 32'(lfsr_clr), 1);
    chk("clr_fast",   32'(fast_en),  0);
    chk("clr_busy",   32'(busy),     1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("wu_fast", 32'(fast_en),  1);
      chk("wu_slow", 32'(slow_en),  1);
      chk("wu_clr",  32'(lfsr_clr), 0);
    end
    cyc(); feed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      #1;
      chk("run1_valid", 32'(byte_valid), 0);
      chk("run1_fast",  32'(fast_en),    1);
      chk("run1_slow",  32'(slow_en),    1);
    end
    cyc(); #1;
    chk("b0_valid", 32'(byte_valid), 1);
    chk("b0_data",  32'(byte_data),  32'h B2);
    cyc(); #1;
    chk("b0_onecyc", 32'(byte_valid), 0);
    byte_ready = 1'b0;

    // Backpressure: byte 1 (5C) held, byte 2 stalls on its last bit
    repeat (6) cyc();
    cyc(); #1;
    chk("b1_valid", 32'(byte_valid), 1);
    chk("b1_data",  32'(byte_data),  32'h5C);
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("bp_fast", 32'(fast_en),   1);
      chk("bp_data", 32'(byte_data), 32'h5C);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      chk("stall_fast",  32'(fast_en),    0);
      chk("stall_slow",  32'(slow_en),    0);
      chk("stall_data",  32'(byte_data),  32'h5C);
      chk("stall_valid", 32'(byte_valid), 1);
    end
    cyc(); byte_ready = 1'b1; #1;
    chk("resume_fast", 32'(fast_en), 1);
    cyc(); #1;
    chk("b2_valid", 32'(byte_valid), 1);
    chk("b2_data",  32'(byte_data),  32'hB2);
    cyc(); #1;
    chk("b2_xfer", 32'(byte_valid), 0);
    repeat (6) cyc();
    cyc(); #1;
    chk("b3_valid", 32'(byte_valid), 1);
    chk("b3_data",  32'(byte_data),  32'h5C);
    stop = 1'b1; #1;
    chk("stop_fast", 32'(fast_en), 0);
    cyc(); stop = 1'b0; #1;
    chk("stop_busy",  32'(busy),       0);
    chk("stop_valid", 32'(byte_valid), 0);
    chk("stop_fast2", 32'(fast_en),    0);

    // Session 2: warmup=0, div_sel=3
    start = 1'b1; warmup = 8'd0; div_sel = 4'd3;
    cyc(); start = 1'b0; idx_clr = 1'b1; #1;
    chk("s2_clr", 32'(lfsr_clr), 1);
    cyc(); idx_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      #1;
      chk("div3_fast", 32'(fast_en), 1);
      chk("div3_slow", 32'(slow_en), (i % 4 == 3) ? 1 : 0);
    end
    cyc(); #1;
    chk("s2_valid", 32'(byte_valid), 1);
    chk("s2_data",  32'(byte_data),  32'hB2);
    repeat (4) cyc();
    cyc(); stop = 1'b1; #1;
    chk("abort_fast", 32'(fast_en), 0);
    chk("abort_busy", 32'(busy),    1);
    cyc(); stop = 1'b0; #1;
    chk("abort_idle",  32'(busy),       0);
    chk("abort_valid", 32'(byte_valid), 0);

    // Session 3: start and stop together in IDLE
    start = 1'b1; stop = 1'b1; div_sel = 4'd0; warmup = 8'd0;
    cyc(); start = 1'b0; stop = 1'b0; idx_clr = 1'b1; #1;
    chk("prio_clr",  32'(lfsr_clr), 1);
    chk("prio_busy", 32'(busy),     1);
    cyc(); idx_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      #1;
      chk("s3_valid", 32'(byte_valid), 0);
      chk("s3_slow",  32'(slow_en),    1);
    end
    cyc(); #1;
    chk("s3_bvalid", 32'(byte_valid), 1);
    chk("s3_data",   32'(byte_data),  32'hB2);
    byte_ready = 1'b0;

    // Asynchronous reset with a byte pending
    cyc(); #1;
    chk("pend_valid", 32'(byte_valid), 1);
    rst = 1'b1; #1;
    chk("arst_valid", 32'(byte_valid), 0);
    chk("arst_data",  32'(byte_data),  0);
    chk("arst_busy",  32'(busy),       0);
    chk("arst_fast",  32'(fast_en),    0);
    chk("arst_clr",   32'(lfsr_clr),   0);
    cyc(); rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("post_valid", 32'(byte_valid), 0);
      chk("post_busy",  32'(busy),       0);
      chk("post_fast",  32'(fast_en),    0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
